// File: rtl/uart_cmd_sequencer.sv
// Frames the UART byte stream into SYNC/OPCODE/ADDR/LEN/payload[/CHECKSUM] host commands.
// Optional checksum byte and CHECK state are built when UART_CMD_CHECKSUM_EN is defined.
module uart_cmd_sequencer #(
    parameter int         ADDR_W         = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [7:0]        cmd_opcode,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    output logic              err_checksum,
    output logic              err_timeout,
    output logic              err_overrun,
    output logic              busy
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
`ifdef UART_CMD_CHECKSUM_EN
        S_CHECK,
`endif
        S_ISSUE
    } state_t;

    // State entered once the last payload byte (or a zero LEN) has been taken.
`ifdef UART_CMD_CHECKSUM_EN
    localparam state_t S_AFTER = S_CHECK;
`else
    localparam state_t S_AFTER = S_ISSUE;
`endif

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic [7:0]       idx;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]       chk;
`else
    assign err_checksum = 1'b0;
`endif

    assign busy = (state != S_IDLE);

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order within the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            tmr         <= '0;
            idx         <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cmd_valid   <= 1'b0;
            cmd_opcode  <= '0;
            cmd_addr    <= '0;
            cmd_len     <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            chk          <= '0;
            err_checksum <= 1'b0;
`endif
        end else begin
            mem_we      <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            err_checksum <= 1'b0;
`endif
            if (state == S_IDLE) begin
                tmr <= '0;
                idx <= '0;
`ifdef UART_CMD_CHECKSUM_EN
                chk <= '0;
`endif
                if (rx_valid && rx_byte == SYNC_BYTE)
                    state <= S_OPCODE;
            end else if (state == S_ISSUE) begin
                tmr <= '0;
                // No byte buffering: anything arriving while a command waits is lost.
                if (rx_valid)
                    err_overrun <= 1'b1;
                if (!cmd_valid) begin
                    cmd_valid <= 1'b1;
                end else if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            end else if (rx_valid) begin
                tmr <= '0;
`ifdef UART_CMD_CHECKSUM_EN
                if (state != S_CHECK)
                    chk <= chk ^ rx_byte;
`endif
                case (state)
                    S_OPCODE: begin
                        cmd_opcode <= rx_byte;
                        state      <= S_ADDR;
                    end
                    S_ADDR: begin
                        cmd_addr <= ADDR_W'(rx_byte);
                        state    <= S_LEN;
                    end
                    S_LEN: begin
                        cmd_len <= rx_byte;
                        idx     <= '0;
                        state   <= (rx_byte == 8'd0) ? S_AFTER : S_PAYLOAD;
                    end
                    S_PAYLOAD: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cmd_addr + ADDR_W'(idx);
                        mem_wdata <= rx_byte;
                        idx       <= idx + 8'd1;
                        if (idx == cmd_len - 8'd1)
                            state <= S_AFTER;
                    end
`ifdef UART_CMD_CHECKSUM_EN
                    S_CHECK: begin
                        if (rx_byte == chk) begin
                            state <= S_ISSUE;
                        end else begin
                            err_checksum <= 1'b1;
                            state        <= S_IDLE;
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end else if (tmr == TMR_LAST) begin
                // A byte landing on the expiry cycle takes the branch above instead.
                err_timeout <= 1'b1;
                state       <= S_IDLE;
            end else begin
                tmr <= tmr + TMR_W'(1);
            end
        end
    end

endmodule
